bcd_display_scan: RTL
=====================

Name: bcd_display_scan

Overview:
Downstream consumer of the 4-bit binary-to-BCD converter. It takes NUM_DIGITS packed BCD digits and holds them in a register. It then time-multiplexes them onto one common seven-segment bus with per-digit enables. The block handles decoding, leading-zero blanking, invalid-code display and the refresh prescaler.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=1)
PRESCALE, 50000, clk cycles each digit stays enabled (>=1)
ACTIVE_LOW, 1, 1: seg and an outputs are active-low; 0: active-high

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous, active-high reset
load  input  1  capture bcd_in into the digit hold register on this edge
bcd_in  input  4*NUM_DIGITS  packed digits; [3:0] = digit 0 (least significant)
blank_lz  input  1  1: blank leading zeros (digit 0 is never blanked)
seg  output  7  segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
an  output  NUM_DIGITS  digit enables, one-hot when active, polarity per ACTIVE_LOW
bad_digit  output  1  high while any held digit code is > 9

Behaviour:
- Reset (rst=1 at an edge):
  - Hold register = 0.
  - Prescaler count = 0.
  - Scan index = 0.
  - bad_digit = 0.
  - seg and an = all segments off / all digits off, i.e. all 1s if ACTIVE_LOW, else all 0s.
  - Reset has priority over load and over a tick. Reset mid-scan aborts the current slot.
- Prescaler:
  - cnt counts 0..PRESCALE-1 and wraps to 0.
  - tick = (cnt == PRESCALE-1).
  - On tick, the index advances; NUM_DIGITS-1 wraps to 0.
  - With PRESCALE=1, the index advances every cycle.
- Hold register:
  - On an edge with load=1, it takes bcd_in.
  - bad_digit is registered from bcd_in on the same edge, so it is valid the cycle after load.
  - Without load, the hold register retains its value.
  - A load does not disturb cnt or index.
- Outputs:
  - seg and an are registered every cycle from the current index and hold register: one-cycle latency.
  - A load at edge N appears on seg at edge N+1 if that digit is the current one.
  - The first edge after reset release drives an = digit 0 enabled and seg = decode(0).
  - an enables exactly one digit: bit index set, all others off.
- Decode (active-high form, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10-15 show a dash (40).
  - Blank = 00.
  - If ACTIVE_LOW=1, seg is the bitwise inverse.
- Leading-zero blanking:
  - Applies when blank_lz=1.
  - Digit k (k>0) is blanked when it and all higher digits are 0.
  - An invalid code counts as nonzero.
  - Blanking affects seg only; an still enables the digit.
  - blank_lz changes take effect with the same one-cycle latency.
- Simultaneous load and tick: the hold update and the index advance both occur. The next-cycle seg shows the new value of the new index.

Test Plan:
1. Reset, then cadence (NUM_DIGITS=4, PRESCALE=4, ACTIVE_LOW=0).
   - Hold rst 3 cycles → seg=00, an=0000.
   - After release: an=0001, seg=3F for 4 cycles.
   - Then an=0010, 0100, 1000, then back to 0001, 4 cycles each.
2. Load value 16'h1234, blank_lz=0 → over one full scan:
   - digit 0: seg=66 (4)
   - digit 1: seg=4F (3)
   - digit 2: seg=5B (2)
   - digit 3: seg=06 (1)
   - bad_digit=0.
3. Leading-zero blanking: load 16'h0070, blank_lz=1.
   - Digits 3 and 2 → seg=00.
   - Digit 1 → 07.
   - Digit 0 → 3F.
   - Load 16'h0000 → only digit 0 shows 3F.
4. Invalid code: load 16'h00A5 → bad_digit=1 the next cycle; digit 1 seg=40; digit 0 seg=6D. Then load 16'h0005 → bad_digit returns to 0.
5. Load mid-slot and load coinciding with tick.
   - Load while digit 2 is active → seg changes exactly one cycle after the load edge; an timing unchanged.
   - Load on the tick edge → next seg is the new value of the next digit.
6. Reset mid-scan with ACTIVE_LOW=1 and load asserted on the same edge.
   - Outputs seg=7F and an=1111; hold register = 0 (load ignored).
   - After release: an=1110, seg=40 (inverted 3F).

Source files
------------

// File: rtl/bcd_display_scan_if.sv
// Bus bundle for bcd_display_scan.
//   load      : capture bcd_in into the digit hold register
//   bcd_in    : packed BCD digits, [3:0] is digit 0 (least significant)
//   blank_lz  : enable leading-zero blanking (digit 0 is never blanked)
//   seg       : shared segment bus {g,f,e,d,c,b,a}
//   an        : per-digit enables, one-hot when active
//   bad_digit : high while any held digit code is above 9
// The master drives the digits and controls; the slave (the scanner) drives
// the display outputs.
interface bcd_display_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    blank_lz;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    bad_digit;

  modport master (
    output load, bcd_in, blank_lz,
    input  seg, an, bad_digit
  );

  modport slave (
    input  load, bcd_in, blank_lz,
    output seg, an, bad_digit
  );
endinterface

// File: rtl/bcd_display_scan.sv
// Multiplexed seven-segment scanner for NUM_DIGITS packed BCD digits.
// Holds the digits in a register, advances a digit index every PRESCALE
// clocks, and drives the decoded digit onto a shared segment bus together
// with a one-hot digit enable. Supports leading-zero blanking and shows a
// dash for codes 10-15.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : bcd_display_scan_if slave (load, bcd_in, blank_lz in;
//         seg, an, bad_digit out)
// Parameters:
//   NUM_DIGITS : digits scanned (>=1)
//   PRESCALE   : clocks each digit stays enabled (>=1)
//   ACTIVE_LOW : 1 = seg/an active-low, 0 = active-high
module bcd_display_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst,
  bcd_display_scan_if.slave  bus
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  // XOR mask that converts active-high segment/enable values to the pin polarity.
  localparam logic POL = (ACTIVE_LOW != 0);

  // Active-high gfedcba pattern; codes 10-15 render as a dash.
  function automatic logic [6:0] decode_digit(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] hold_q, hold_d;
  logic                    bad_q, bad_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    tick;
  logic                    zero_above;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [3:0]              cur_digit;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   an_raw;

  always_comb begin
    tick       = 1'b0;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    bad_d      = bad_q;
    zero_above = 1'b1;
    blank_mask = '0;
    cur_digit  = 4'd0;
    seg_raw    = 7'h00;
    an_raw     = '0;

    // Refresh prescaler and scan index.
    tick = (cnt_q == CNT_LAST);
    if (tick) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Hold register; bad_digit is judged on the incoming word so it is
    // valid together with the new hold contents.
    if (bus.load) begin
      hold_d = bus.bcd_in;
      bad_d  = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (bus.bcd_in[4*k +: 4] > 4'd9) bad_d = 1'b1;
      end
    end

    // A digit is a leading zero when it and every higher digit are zero.
    // Any nonzero code, including invalid ones, breaks the chain.
    // Bit 0 stays clear so the last digit always shows.
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above    = zero_above & (hold_q[4*k +: 4] == 4'd0);
      blank_mask[k] = zero_above;
    end

    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_digit = hold_q[4*k +: 4];
        an_raw[k] = 1'b1;
      end
    end

    // Blanking removes the segments only; the digit enable stays on.
    if (bus.blank_lz && blank_mask[idx_q]) seg_raw = 7'h00;
    else                                   seg_raw = decode_digit(cur_digit);

    seg_d = seg_raw ^ {7{POL}};
    an_d  = an_raw ^ {NUM_DIGITS{POL}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      hold_q <= '0;
      bad_q  <= 1'b0;
      seg_q  <= {7{POL}};
      an_q   <= {NUM_DIGITS{POL}};
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      hold_q <= hold_d;
      bad_q  <= bad_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.bad_digit = bad_q;

endmodule
